// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: parametrised register bank on the user side of the
// axi_lite_slave simple register interface. It holds NUM_CTRL read/write
// control words with byte strobes, NUM_STAT read-only status words, and a
// write-1-to-clear interrupt status/enable pair that drives a level interrupt.
// Optional build macro: REGBANK_ALIGN_CHECK_EN. When defined, addresses whose
// low log2(DATA_WIDTH/8) bits are nonzero are flagged invalid instead of
// being rounded down to the word boundary.

module axi_lite_regbank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 2,
  parameter int NUM_IRQ    = 8,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [ADDR_WIDTH-1:0]                          i_reg_address,
  output logic                                           o_reg_invalid_addr,
  input  logic                                           i_reg_in_rdy,
  output logic                                           o_reg_in_ack_stb,
  input  logic [DATA_WIDTH-1:0]                          i_reg_in_data,
  input  logic [DATA_WIDTH/8-1:0]                        i_reg_in_strb,
  input  logic                                           i_reg_out_req,
  output logic                                           o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]                          o_reg_out_data,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]                 o_ctrl,
  // Kept at least one word wide so a bank without status words still elaborates.
  input  logic [(NUM_STAT > 0 ? NUM_STAT : 1)*DATA_WIDTH-1:0] i_status,
  input  logic [NUM_IRQ-1:0]                             i_irq_src,
  output logic                                           o_irq
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] IDX_STAT       = ADDR_WIDTH'(NUM_CTRL);
  localparam logic [ADDR_WIDTH-1:0] IDX_INT_STATUS = ADDR_WIDTH'(NUM_CTRL + NUM_STAT);
  localparam logic [ADDR_WIDTH-1:0] IDX_INT_ENABLE = ADDR_WIDTH'(NUM_CTRL + NUM_STAT + 1);
`ifdef REGBANK_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK       = ADDR_WIDTH'((1 << LSB) - 1);
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;

  logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic [NUM_IRQ-1:0]    int_status_q;
  logic [NUM_IRQ-1:0]    int_enable_q;

  logic [ADDR_WIDTH-1:0] addr_index;
  logic                  aligned;
  logic                  hit_ctrl;
  logic                  hit_stat;
  logic                  hit_int_status;
  logic                  hit_int_enable;
  logic                  addr_valid;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] rd_value;
  logic [NUM_IRQ-1:0]    irq_mask;
  logic [NUM_IRQ-1:0]    int_enable_next;
  logic [NUM_IRQ-1:0]    int_clear;

  assign addr_index = addr_q >> LSB;

  // Classify the latched address into one of the register regions.
  always_comb begin
    aligned = 1'b1;
`ifdef REGBANK_ALIGN_CHECK_EN
    aligned = ((addr_q & LOW_MASK) == '0);
`endif
    hit_ctrl       = aligned && (addr_index < IDX_STAT);
    hit_stat       = aligned && (addr_index >= IDX_STAT) && (addr_index < IDX_INT_STATUS);
    hit_int_status = aligned && (addr_index == IDX_INT_STATUS);
    hit_int_enable = aligned && (addr_index == IDX_INT_ENABLE);
    addr_valid     = hit_ctrl || hit_stat || hit_int_status || hit_int_enable;
  end

  // Expand the latched byte strobes into a per-bit write mask.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      byte_mask[b*8 +: 8] = {8{strb_q[b]}};
    end
  end

  // Select the word returned by a read; unmapped addresses read as zero.
  always_comb begin
    rd_value = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (hit_ctrl && (addr_index == ADDR_WIDTH'(k))) begin
        rd_value = ctrl_q[k];
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (hit_stat && (addr_index == ADDR_WIDTH'(NUM_CTRL + k))) begin
        rd_value = i_status[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (hit_int_status) begin
      rd_value = DATA_WIDTH'(int_status_q);
    end
    if (hit_int_enable) begin
      rd_value = DATA_WIDTH'(int_enable_q);
    end
  end

  // Interrupt-register write data: byte-merged enable and W1C clear bits.
  always_comb begin
    irq_mask        = byte_mask[NUM_IRQ-1:0];
    int_enable_next = (int_enable_q & ~irq_mask) | (data_q[NUM_IRQ-1:0] & irq_mask);
    int_clear       = '0;
    if ((state_q == WRITE) && hit_int_status) begin
      int_clear = data_q[NUM_IRQ-1:0] & irq_mask;
    end
  end

  // Request sequencer: latch one request, service it, then wait for the
  // requester to drop its lines so a held request is not serviced twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      data_q             <= '0;
      strb_q             <= '0;
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_invalid_addr <= 1'b0;
      o_reg_out_data     <= '0;
    end else begin
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_invalid_addr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_reg_in_rdy) begin
            addr_q  <= i_reg_address;
            data_q  <= i_reg_in_data;
            strb_q  <= i_reg_in_strb;
            state_q <= WRITE;
          end else if (i_reg_out_req) begin
            addr_q  <= i_reg_address;
            state_q <= READ;
          end
        end
        WRITE: begin
          o_reg_in_ack_stb   <= 1'b1;
          o_reg_invalid_addr <= !addr_valid;
          state_q            <= DRAIN;
        end
        READ: begin
          o_reg_out_rdy_stb  <= 1'b1;
          o_reg_invalid_addr <= !addr_valid;
          o_reg_out_data     <= rd_value;
          state_q            <= DRAIN;
        end
        DRAIN: begin
          if (!i_reg_in_rdy && !i_reg_out_req) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control registers take byte-strobed writes while in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= CTRL_RESET;
      end
    end else if ((state_q == WRITE) && hit_ctrl) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (addr_index == ADDR_WIDTH'(k)) begin
          ctrl_q[k] <= (ctrl_q[k] & ~byte_mask) | (data_q & byte_mask);
        end
      end
    end
  end

  // Interrupt status accumulates sources (a set beats a same-cycle clear),
  // and the request line is registered from the pre-update status/enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_status_q <= '0;
      int_enable_q <= '0;
      o_irq        <= 1'b0;
    end else begin
      int_status_q <= (int_status_q & ~int_clear) | i_irq_src;
      if ((state_q == WRITE) && hit_int_enable) begin
        int_enable_q <= int_enable_next;
      end
      o_irq <= |(int_status_q & int_enable_q);
    end
  end

  // Flatten the control registers onto the packed output bus.
  always_comb begin
    o_ctrl = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      o_ctrl[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: self-checking bench for axi_lite_regbank at default
// widths (4 control, 2 status, 8 interrupt sources) with CTRL_RESET=0xA5A5A5A5.
// A transaction-level model of the register map tracks expected state.

module tb_axi_lite_regbank;

  localparam logic [31:0] CRST = 32'hA5A5A5A5;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_reg_address;
  logic         o_reg_invalid_addr;
  logic         i_reg_in_rdy;
  logic         o_reg_in_ack_stb;
  logic [31:0]  i_reg_in_data;
  logic [3:0]   i_reg_in_strb;
  logic         i_reg_out_req;
  logic         o_reg_out_rdy_stb;
  logic [31:0]  o_reg_out_data;
  logic [127:0] o_ctrl;
  logic [63:0]  i_status;
  logic [7:0]   i_irq_src;
  logic         o_irq;

  axi_lite_regbank #(
    .CTRL_RESET(CRST)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_reg_address      (i_reg_address),
    .o_reg_invalid_addr (o_reg_invalid_addr),
    .i_reg_in_rdy       (i_reg_in_rdy),
    .o_reg_in_ack_stb   (o_reg_in_ack_stb),
    .i_reg_in_data      (i_reg_in_data),
    .i_reg_in_strb      (i_reg_in_strb),
    .i_reg_out_req      (i_reg_out_req),
    .o_reg_out_rdy_stb  (o_reg_out_rdy_stb),
    .o_reg_out_data     (o_reg_out_data),
    .o_ctrl             (o_ctrl),
    .i_status           (i_status),
    .i_irq_src          (i_irq_src),
    .o_irq              (o_irq)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the register map
  logic [31:0] ctrl_m [4];
  logic [7:0]  ist_m;
  logic [7:0]  ien_m;
  logic        irq_m;
  logic [31:0] out_m;
  bit          pend_wr = 0;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;
  bit          rand_irq = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic        exp_inv;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) ctrl_m[k] = CRST;
    ist_m = 8'h00;
    ien_m = 8'h00;
    irq_m = 1'b0;
    out_m = 32'h0;
  endfunction

  function automatic bit model_addr_ok(input logic [31:0] a);
`ifdef REGBANK_ALIGN_CHECK_EN
    if ((a % 4) != 0) return 1'b0;
`endif
    return (a / 4) <= 7;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output logic inv);
    int unsigned idx;
    idx = a / 4;
    inv = !model_addr_ok(a);
    if (inv) return 32'h0;
    if (idx < 4) return ctrl_m[idx];
    if (idx < 6) return i_status[(idx-4)*32 +: 32];
    if (idx == 6) return {24'h0, ist_m};
    return {24'h0, ien_m};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned idx;
    logic [31:0] m;
    idx = a / 4;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (!model_addr_ok(a)) return;
    if (idx < 4) ctrl_m[idx] = (ctrl_m[idx] & ~m) | (d & m);
    else if (idx == 6) ist_m = ist_m & ~(d[7:0] & m[7:0]);
    else if (idx == 7) ien_m = (ien_m & ~m[7:0]) | (d[7:0] & m[7:0]);
  endfunction

  // Advance one clock edge, updating the model for what that edge does.
  task automatic tick();
    logic irq_next;
    if (rand_irq) i_irq_src = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
    irq_next = |(ist_m & ien_m);
    if (rst) begin
      model_reset();
    end else begin
      if (pend_wr) model_write(pend_addr, pend_data, pend_strb);
      ist_m = ist_m | i_irq_src;
      irq_m = irq_next;
    end
    pend_wr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic inv);
    i_reg_address = a;
    i_reg_in_data = d;
    i_reg_in_strb = s;
    i_reg_in_rdy  = 1'b1;
    tick();
    check("wr_ack_early", o_reg_in_ack_stb, 1'b0);
    pend_wr = 1; pend_addr = a; pend_data = d; pend_strb = s;
    tick();
    check("wr_ack", o_reg_in_ack_stb, 1'b1);
    check("wr_no_rdy", o_reg_out_rdy_stb, 1'b0);
    inv = o_reg_invalid_addr;
    i_reg_in_rdy = 1'b0;
    tick();
    check("wr_ack_pulse", o_reg_in_ack_stb, 1'b0);
    check("wr_inv_pulse", o_reg_invalid_addr, 1'b0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] act, output logic inv,
                          output logic [31:0] exp, output logic exp_inv);
    i_reg_address = a;
    i_reg_out_req = 1'b1;
    tick();
    check("rd_rdy_early", o_reg_out_rdy_stb, 1'b0);
    exp = model_read(a, exp_inv);
    tick();
    check("rd_rdy", o_reg_out_rdy_stb, 1'b1);
    check("rd_no_ack", o_reg_in_ack_stb, 1'b0);
    act = o_reg_out_data;
    inv = o_reg_invalid_addr;
    out_m = exp;
    i_reg_out_req = 1'b0;
    tick();
    check("rd_rdy_pulse", o_reg_out_rdy_stb, 1'b0);
  endtask

  task automatic apply_stimulus(input vec_t v, output logic [31:0] act, output logic inv);
    logic [31:0] e;
    logic        ei;
    if (v.is_read) bus_read(v.addr, act, inv, e, ei);
    else begin
      bus_write(v.addr, v.data, v.strb, inv);
      act = 32'h0;
    end
  endtask

  task automatic check_output();
    check("ctrl", o_ctrl, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});
    check("irq", o_irq, irq_m);
    check("out_data_hold", o_reg_out_data, out_m);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] act, exp, a, d;
    logic        inv, exp_inv;
    int          acks, rdys;

    vecs[0]  = '{1'b1, 32'h00, 32'h0,        4'h0, CRST,         1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h04, 32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h04, 32'h0,        4'h0, 32'h00220044, 1'b0};
    vecs[4]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'hCAFE0001, 1'b0};
    vecs[5]  = '{1'b1, 32'h14, 32'h0,        4'h0, 32'hBEEF0002, 1'b0};
    vecs[6]  = '{1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'hCAFE0001, 1'b0};
    vecs[8]  = '{1'b1, 32'h20, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h08, 32'h0,        4'h0, CRST,         1'b0};
    vecs[11] = '{1'b1, 32'h04, 32'h0,        4'h0, 32'h00220044, 1'b0};
    vecs[12] = '{1'b0, 32'h1C, 32'hFFFFFFFF, 4'h1, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 32'h1C, 32'h0,        4'h0, 32'h000000FF, 1'b0};
    vecs[14] = '{1'b0, 32'h1C, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b1, 32'h1C, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 32'h0C, 32'h12345678, 4'h8, 32'h0,        1'b0};
    vecs[17] = '{1'b1, 32'h0C, 32'h0,        4'h0, 32'h12A5A5A5, 1'b0};

    rst = 1'b1;
    i_reg_address = '0; i_reg_in_rdy = 1'b0; i_reg_in_data = '0; i_reg_in_strb = '0;
    i_reg_out_req = 1'b0; i_irq_src = '0;
    i_status = {32'hBEEF0002, 32'hCAFE0001};
    model_reset();

    // Reset state
    tick(); tick(); tick();
    check("rst_ctrl", o_ctrl, {4{CRST}});
    check("rst_irq", o_irq, 1'b0);
    check("rst_out_data", o_reg_out_data, 32'h0);
    check("rst_ack", o_reg_in_ack_stb, 1'b0);
    check("rst_rdy", o_reg_out_rdy_stb, 1'b0);
    check("rst_inv", o_reg_invalid_addr, 1'b0);
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i], act, inv);
      check($sformatf("vec%0d_inv", i), inv, vecs[i].exp_inv);
      if (vecs[i].is_read) check($sformatf("vec%0d_data", i), act, vecs[i].exp_data);
      check_output();
    end
    check("ctrl1_slice", o_ctrl[63:32], 32'h00220044);

    // Interrupt set, enable, and W1C against an active source
    i_irq_src = 8'h05;
    tick();
    i_irq_src = 8'h00;
    bus_write(32'h1C, 32'h04, 4'hF, inv);
    check("irq_set", o_irq, 1'b1);
    check_output();
    i_irq_src = 8'h04;
    bus_write(32'h18, 32'h04, 4'hF, inv);
    bus_read(32'h18, act, inv, exp, exp_inv);
    check("irq_set_wins", act, 32'h05);
    check_output();
    i_irq_src = 8'h00;
    bus_write(32'h18, 32'h04, 4'hF, inv);
    bus_read(32'h18, act, inv, exp, exp_inv);
    check("irq_w1c", act, 32'h01);
    check("irq_cleared", o_irq, 1'b0);
    check_output();

    // Write and read requested together and held for four cycles
    i_reg_address = 32'h04; i_reg_in_data = 32'hDEADBEEF; i_reg_in_strb = 4'hF;
    i_reg_in_rdy = 1'b1; i_reg_out_req = 1'b1;
    acks = 0; rdys = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        pend_wr = 1; pend_addr = 32'h04; pend_data = 32'hDEADBEEF; pend_strb = 4'hF;
      end
      tick();
      acks += int'(o_reg_in_ack_stb);
      rdys += int'(o_reg_out_rdy_stb);
    end
    i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0;
    tick();
    acks += int'(o_reg_in_ack_stb);
    rdys += int'(o_reg_out_rdy_stb);
    check("both_ack_count", acks, 1);
    check("both_no_rdy", rdys, 0);
    bus_read(32'h04, act, inv, exp, exp_inv);
    check("both_readback", act, 32'hDEADBEEF);
    check_output();

    // Reset while a write is in flight
    i_reg_address = 32'h00; i_reg_in_data = 32'h0; i_reg_in_strb = 4'hF; i_reg_in_rdy = 1'b1;
    tick();
    rst = 1'b1; i_reg_in_rdy = 1'b0;
    tick();
    check("rstwr_no_ack", o_reg_in_ack_stb, 1'b0);
    check("rstwr_ctrl", o_ctrl, {4{CRST}});
    rst = 1'b0;
    tick();
    check("rstwr_no_ack_after", o_reg_in_ack_stb, 1'b0);
    check("rstwr_ctrl_after", o_ctrl, {4{CRST}});
    check_output();

    // Misaligned write
    bus_write(32'h02, 32'h77777777, 4'hF, inv);
`ifdef REGBANK_ALIGN_CHECK_EN
    check("misaligned_inv", inv, 1'b1);
    check("misaligned_ctrl0", o_ctrl[31:0], CRST);
`else
    check("misaligned_inv", inv, 1'b0);
    check("misaligned_ctrl0", o_ctrl[31:0], 32'h77777777);
`endif
    check_output();

    // Randomised traffic against the model
    rand_irq = 1;
    for (int n = 0; n < 60; n++) begin
      i_status = {32'($urandom), 32'($urandom)};
      a = 32'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        bus_read(a, act, inv, exp, exp_inv);
        check("rand_rd_data", act, exp);
        check("rand_rd_inv", inv, exp_inv);
      end else begin
        d = $urandom;
        exp_inv = !model_addr_ok(a);
        bus_write(a, d, 4'($urandom), inv);
        check("rand_wr_inv", inv, exp_inv);
      end
      check_output();
    end
    rand_irq = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised register bank on the user side of axi_lite_slave's simple register interface; successor to the fixed two-register demo bank.
- Provides NUM_CTRL read/write control registers with byte-strobe writes, NUM_STAT read-only status words, and a write-1-to-clear interrupt status/enable pair driving a level interrupt.
- One request at a time, sequenced by a small FSM.

Parameters:
- ADDR_WIDTH, 32, width of i_reg_address.
- DATA_WIDTH, 32, register width; multiple of 8.
- NUM_CTRL, 4, number of RW control registers (>=1).
- NUM_STAT, 2, number of RO status registers (>=0).
- NUM_IRQ, 8, interrupt source count (1..DATA_WIDTH).
- CTRL_RESET, 0, reset value loaded into every control register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_reg_address  in  ADDR_WIDTH  byte address from slave
- o_reg_invalid_addr  out  1  invalid-address flag, valid with ack/rdy strobe
- i_reg_in_rdy  in  1  write data available
- o_reg_in_ack_stb  out  1  one-cycle write-done strobe
- i_reg_in_data  in  DATA_WIDTH  write data
- i_reg_in_strb  in  DATA_WIDTH/8  byte write enables
- i_reg_out_req  in  1  read request
- o_reg_out_rdy_stb  out  1  one-cycle read-data-valid strobe
- o_reg_out_data  out  DATA_WIDTH  read data
- o_ctrl  out  NUM_CTRL*DATA_WIDTH  control registers, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_status  in  NUM_STAT*DATA_WIDTH  status words, same packing
- i_irq_src  in  NUM_IRQ  interrupt set pulses/levels
- o_irq  out  1  registered interrupt request

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Address map: W = DATA_WIDTH/8 byte stride, index = address / W.
  - Index 0..NUM_CTRL-1: CTRL.
  - Index NUM_CTRL..NUM_CTRL+NUM_STAT-1: STAT.
  - Index NUM_CTRL+NUM_STAT: INT_STATUS.
  - Index NUM_CTRL+NUM_STAT+1: INT_ENABLE.
  - Any higher index is invalid.
- Reset values:
  - CTRL = CTRL_RESET; INT_STATUS = 0; INT_ENABLE = 0.
  - o_reg_out_data = 0; all strobes, o_reg_invalid_addr and o_irq = 0.
  - FSM returns to IDLE; a request in flight is dropped with no ack.
- FSM states: IDLE, WRITE, READ, DRAIN.
  - IDLE: if i_reg_in_rdy, latch address/data/strb and go to WRITE. Else if i_reg_out_req, latch address and go to READ. Write wins when both are high.
  - WRITE (1 cycle):
    - CTRL: byte lanes with strb=1 are updated, others held.
    - INT_STATUS: bits written 1 (within strobed lanes) are cleared.
    - INT_ENABLE: byte-strobed update; bits >= NUM_IRQ read 0.
    - STAT: write ignored, not flagged invalid.
    - Invalid index: no state change, o_reg_invalid_addr=1.
    - o_reg_in_ack_stb=1 on the cycle after WRITE is entered; next state DRAIN.
  - READ (1 cycle): o_reg_out_data loads the selected register (STAT sampled from i_status this cycle; invalid index returns 0 with o_reg_invalid_addr=1). o_reg_out_rdy_stb=1 the following cycle; next state DRAIN.
  - DRAIN: stay until i_reg_in_rdy=0 and i_reg_out_req=0, then IDLE. This prevents double-servicing a held request.
- Latency: strobe asserted 2 cycles after the request is first sampled in IDLE.
- Strobes and o_reg_invalid_addr are single-cycle pulses and default to 0.
- Interrupts:
  - Each cycle, INT_STATUS[i] |= i_irq_src[i]. A set wins over a simultaneous W1C clear of the same bit.
  - o_irq registered as |(INT_STATUS & INT_ENABLE), one cycle after the status/enable change.
- o_reg_out_data holds its last value between reads.

Optional Feature:
- REGBANK_ALIGN_CHECK_EN defined: address with nonzero low log2(W) bits is invalid. Write → no state change, invalid=1, ack still given. Read → returns 0, invalid=1.
- Undefined: low log2(W) address bits are ignored (address rounded down).

Test Plan:
- Reset, then read address 0 with CTRL_RESET=0xA5A5A5A5 → rdy_stb 2 cycles after req, data 0xA5A5A5A5, invalid=0.
- Write 0x11223344 to 0x4 with strb=4'b0101, prior value 0 → o_ctrl[63:32]=0x00220044, ack pulse of one cycle, readback matches.
- i_irq_src=8'h05 pulse, write INT_ENABLE=0x04 → o_irq=1 one cycle later. Then W1C 0x04 while i_irq_src[2]=1 → bit stays set. Repeat W1C with source low → INT_STATUS=0x01, o_irq=0.
- Read index NUM_CTRL+NUM_STAT+2 (0x20 at defaults) → data 0, invalid=1 with rdy_stb. Write to the same address → no register changes, invalid=1 with ack.
- i_reg_in_rdy and i_reg_out_req high together, held 4 cycles → exactly one ack, no rdy_stb until both drop and a new read is issued.
- rst asserted in WRITE state → no ack, CTRL back to reset values; with REGBANK_ALIGN_CHECK_EN, write to 0x2 → invalid=1, CTRL unchanged.
